// File: rtl/seg_scan_decoder.sv
// Loopback monitor for a multiplexed active-low 7-segment bus: rebuilds the displayed
// hex value per digit and publishes complete frames atomically.
module seg_scan_decoder #(
   parameter int DIGITS        = 8,
   parameter int STABLE_CYCLES = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DIGITS-1:0]     an,
   input  logic [7:0]            seg,
   output logic [4*DIGITS-1:0]   value,
   output logic [DIGITS-1:0]     dp,
   output logic [DIGITS-1:0]     blank,
   output logic                  err,
   output logic                  frame_valid
);

   localparam int CW = $clog2(STABLE_CYCLES + 1);
   localparam logic [CW-1:0] STB = CW'(STABLE_CYCLES);

   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] SETTLE = 2'd1;
   localparam logic [1:0] HOLD   = 2'd2;

   logic [DIGITS-1:0]        an_q, an_p_q;
   logic [7:0]               seg_q, seg_p_q;
   logic [1:0]               state_q, state_d;
   logic [CW-1:0]            cnt_q, cnt_d, cnt_n;
   logic [DIGITS-1:0]        seen_q, seen_d;
   logic [DIGITS-1:0][3:0]   val_sh_q;
   logic [DIGITS-1:0]        dp_sh_q, blank_sh_q, err_sh_q, err_sh_d;
   logic [4*DIGITS-1:0]      value_q;
   logic [DIGITS-1:0]        dp_q, blank_q;
   logic                     err_q, fv_q;

   logic [DIGITS-1:0] sel;
   logic              one_hot, same, cap, pub;
   logic [3:0]        dec_nib;
   logic              dec_blank, dec_err;

   // dp is decoded separately, so the pattern lookup always sees dp off
   always_comb begin
      dec_nib   = 4'h0;
      dec_blank = 1'b0;
      dec_err   = 1'b0;
      case ({1'b1, seg_q[6:0]})
         8'hC0: dec_nib = 4'h0;
         8'hF9: dec_nib = 4'h1;
         8'hA4: dec_nib = 4'h2;
         8'hB0: dec_nib = 4'h3;
         8'h99: dec_nib = 4'h4;
         8'h92: dec_nib = 4'h5;
         8'h82: dec_nib = 4'h6;
         8'hF8: dec_nib = 4'h7;
         8'h80: dec_nib = 4'h8;
         8'h98: dec_nib = 4'h9;
         8'h88: dec_nib = 4'hA;
         8'h83: dec_nib = 4'hB;
         8'hC6: dec_nib = 4'hC;
         8'hA1: dec_nib = 4'hD;
         8'h86: dec_nib = 4'hE;
         8'h8E: dec_nib = 4'hF;
         8'hFF: dec_blank = 1'b1;
         default: dec_err = 1'b1;
      endcase
   end

   always_comb begin
      sel     = ~an_q;
      one_hot = $onehot(sel);
      same    = (an_q == an_p_q) && (seg_q == seg_p_q);
      state_d = state_q;
      cnt_d   = cnt_q;
      cnt_n   = cnt_q;
      cap     = 1'b0;
      if (!one_hot) begin
         state_d = IDLE;
         cnt_d   = '0;
      end else if (!(state_q == HOLD && same)) begin
         cnt_n = (state_q == IDLE || !same) ? CW'(1) : cnt_q + CW'(1);
         cnt_d = cnt_n;
         if (cnt_n == STB) begin
            cap     = 1'b1;
            state_d = HOLD;
         end else begin
            state_d = SETTLE;
         end
      end
   end

   // seen stays all-ones for exactly one cycle; a capture on that edge starts the next frame
   always_comb begin
      pub      = &seen_q;
      seen_d   = (pub ? '0 : seen_q) | (cap ? sel : '0);
      err_sh_d = pub ? '0 : err_sh_q;
      for (int k = 0; k < DIGITS; k++)
         if (cap && sel[k]) err_sh_d[k] = dec_err;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         an_q       <= '1;
         seg_q      <= '1;
         an_p_q     <= '1;
         seg_p_q    <= '1;
         state_q    <= IDLE;
         cnt_q      <= '0;
         seen_q     <= '0;
         val_sh_q   <= '0;
         dp_sh_q    <= '0;
         blank_sh_q <= '0;
         err_sh_q   <= '0;
         value_q    <= '0;
         dp_q       <= '0;
         blank_q    <= '1;
         err_q      <= 1'b0;
         fv_q       <= 1'b0;
      end else begin
         an_q     <= an;
         seg_q    <= seg;
         an_p_q   <= an_q;
         seg_p_q  <= seg_q;
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         seen_q   <= seen_d;
         err_sh_q <= err_sh_d;
         for (int k = 0; k < DIGITS; k++) begin
            if (cap && sel[k]) begin
               val_sh_q[k]   <= dec_nib;
               dp_sh_q[k]    <= ~seg_q[7];
               blank_sh_q[k] <= dec_blank;
            end
         end
         fv_q <= pub;
         if (pub) begin
            value_q <= val_sh_q;
            dp_q    <= dp_sh_q;
            blank_q <= blank_sh_q;
            err_q   <= |err_sh_q;
         end
      end
   end

   assign value       = value_q;
   assign dp          = dp_q;
   assign blank       = blank_q;
   assign err         = err_q;
   assign frame_valid = fv_q;

endmodule
